wbu_queue: RTL and testbench
============================

Name: wbu_queue

Overview:
- Parametrised successor to the single-register writeback stage.
- Sits between LSU and regfile write port, inside the valid/ready pipeline.
- Buffers up to DEPTH retired results in a circular queue and absorbs regfile back-pressure (regfile ready is no longer tied high).
- Exposes a two-port bypass lookup so decode can forward results that are still queued and not yet written.

Parameters:
- XLEN, 64, data width of results and bypass data.
- REG_ADDRW, 5, register index width.
- DEPTH, 2, queue entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_pre_valid  in  1  LSU has a result.
- o_pre_ready  out  1  queue can accept this cycle.
- i_lsu_exres  in  XLEN  execute result.
- i_lsu_lsres  in  XLEN  load result.
- i_lsu_rdid  in  REG_ADDRW  destination register.
- i_lsu_rdwen  in  1  instruction writes rd.
- i_lsu_lden  in  1  select lsres over exres.
- i_post_ready  in  1  regfile write port accepts head.
- o_wbu_valid  out  1  head entry present.
- o_wbu_rdwen  out  1  regfile write enable.
- o_wbu_rd  out  XLEN  write data.
- o_wbu_rdid  out  REG_ADDRW  write index.
- i_rs1id, i_rs2id  in  REG_ADDRW each  bypass lookup indices.
- o_rs1_hit, o_rs2_hit  out  1 each  queued producer found.
- o_rs1_data, o_rs2_data  out  XLEN each  forwarded value.
- o_wbu_count  out  clog2(DEPTH)+1  occupancy.

Behaviour:
- Storage and pointers:
  - Each entry holds {data, rdid, rdwen}, where data = i_lsu_lden ? i_lsu_lsres : i_lsu_exres, selected at push.
  - Read and write pointers are clog2(DEPTH)+1 bits.
  - empty = pointers equal. full = index bits equal and MSB differs. Pointers wrap modulo 2*DEPTH.
- Push and pop:
  - push = i_pre_valid & o_pre_ready. pop = o_wbu_valid & i_post_ready.
  - o_pre_ready = !full | i_post_ready. When full, a push is accepted in the same cycle as a pop. This is a deliberate combinational ready path.
- Head outputs:
  - o_wbu_valid = !empty.
  - o_wbu_rdwen = o_wbu_valid & i_post_ready & head.rdwen & (head.rdid != 0).
  - o_wbu_rd and o_wbu_rdid show the head entry; both are 0 when empty.
- Latency: a pushed entry is visible at the head no earlier than the next cycle. There is no flow-through, even when empty.
- Occupancy: o_wbu_count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push+pop or when idle. Range is 0..DEPTH.
- Entries with rdwen=0 or rdid=0 still occupy a slot and drain normally. They never assert o_wbu_rdwen and never hit in bypass.
- Bypass:
  - Scans all valid entries, including the head.
  - A match requires entry.rdwen, entry.rdid == rsNid, and rsNid != 0.
  - When several entries match, the youngest (closest to the write pointer) wins.
  - An entry popping this cycle still participates.
  - The incoming (not yet pushed) LSU result does not participate.
  - On a miss: hit=0, data=0. The lookup is purely combinational.
- Reset (asynchronous, i_rst_n low):
  - Pointers and count go to 0.
  - o_wbu_valid, o_wbu_rdwen, o_rs1_hit and o_rs2_hit go to 0.
  - All data and index outputs go to 0.
  - Entry contents may be left uncleared but must be unobservable.
  - Reset mid-drain discards all queued entries.
- Stall: with i_post_ready=0 the head is held stable; o_wbu_rd and o_wbu_rdid do not change.

Optional Feature:
- Macro: WBU_QUEUE_DIFFTEST_EN.
- When defined:
  - Adds inputs s_lsu_diffpc (XLEN) and s_lsu_ins (32), stored per entry.
  - Adds outputs s_wbu_diffpc and s_wbu_ins, showing the head entry (0 when empty).
  - Adds s_wbu_commit (1), which equals pop, for the simulation commit/difftest hook.
- When undefined: these ports and storage do not exist, and the behaviour above is unchanged.

Test Plan:
- Reset, then push {exres=0x11, rdid=5, rdwen=1, lden=0} with i_post_ready=1: next cycle o_wbu_rdwen=1, rd=0x11, rdid=5, count=1; the cycle after, count=0 and valid=0.
- i_post_ready=0, push 0xA (rd 3), then 0xB (rd 4) with DEPTH=2: count=2 and o_pre_ready=0. Raise i_post_ready with a third push pending: the third push is accepted that same cycle, count stays 2, and the head becomes 0xB.
- Push lden=1 with lsres=0xDEAD, exres=0xBEEF: head data = 0xDEAD.
- Queue holds rd 7 = 0x1 (older) and rd 7 = 0x2 (younger); i_rs1id=7 gives hit=1, data=0x2. i_rs2id=0 gives hit=0, including when an entry has rdid=0 and rdwen=1.
- Push an entry with rdwen=0: it drains one cycle later with o_wbu_rdwen=0, and the count returns to 0.
- Assert i_rst_n=0 asynchronously with 2 entries queued: valid, count and hits go to 0 immediately, and there is no rdwen pulse after release.

Source files
------------

// File: rtl/wbu_queue.sv
// Writeback queue: buffers DEPTH retired results ahead of the regfile write port, with a two-port bypass lookup.
// Optional difftest side-band (per-entry pc/instruction, commit strobe) under `WBU_QUEUE_DIFFTEST_EN.
module wbu_queue #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned REG_ADDRW = 5,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_pre_valid,
    output logic                     o_pre_ready,
    input  logic [XLEN-1:0]          i_lsu_exres,
    input  logic [XLEN-1:0]          i_lsu_lsres,
    input  logic [REG_ADDRW-1:0]     i_lsu_rdid,
    input  logic                     i_lsu_rdwen,
    input  logic                     i_lsu_lden,
`ifdef WBU_QUEUE_DIFFTEST_EN
    input  logic [XLEN-1:0]          s_lsu_diffpc,
    input  logic [31:0]              s_lsu_ins,
    output logic [XLEN-1:0]          s_wbu_diffpc,
    output logic [31:0]              s_wbu_ins,
    output logic                     s_wbu_commit,
`endif
    input  logic                     i_post_ready,
    output logic                     o_wbu_valid,
    output logic                     o_wbu_rdwen,
    output logic [XLEN-1:0]          o_wbu_rd,
    output logic [REG_ADDRW-1:0]     o_wbu_rdid,
    input  logic [REG_ADDRW-1:0]     i_rs1id,
    input  logic [REG_ADDRW-1:0]     i_rs2id,
    output logic                     o_rs1_hit,
    output logic                     o_rs2_hit,
    output logic [XLEN-1:0]          o_rs1_data,
    output logic [XLEN-1:0]          o_rs2_data,
    output logic [$clog2(DEPTH):0]   o_wbu_count
);

    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned PTRW = IDXW + 1;

    logic [PTRW-1:0]      r_wptr;
    logic [PTRW-1:0]      r_rptr;
    logic [PTRW-1:0]      r_count;
    logic [XLEN-1:0]      r_data  [DEPTH];
    logic [REG_ADDRW-1:0] r_rdid  [DEPTH];
    logic                 r_rdwen [DEPTH];

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [IDXW-1:0] w_widx;
    logic [IDXW-1:0] w_ridx;

    assign w_widx  = r_wptr[IDXW-1:0];
    assign w_ridx  = r_rptr[IDXW-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_widx == w_ridx) && (r_wptr[IDXW] != r_rptr[IDXW]);

    // Ready depends on i_post_ready so a full queue can take a push in the cycle it pops.
    assign o_pre_ready = !w_full || i_post_ready;
    assign w_push      = i_pre_valid && o_pre_ready;
    assign w_pop       = o_wbu_valid && i_post_ready;

    assign o_wbu_valid = !w_empty;
    assign o_wbu_rdwen = o_wbu_valid && i_post_ready && r_rdwen[w_ridx] && (r_rdid[w_ridx] != '0);
    assign o_wbu_rd    = w_empty ? '0 : r_data[w_ridx];
    assign o_wbu_rdid  = w_empty ? '0 : r_rdid[w_ridx];
    assign o_wbu_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTRW'(1);
            if (w_pop)  r_rptr <= r_rptr + PTRW'(1);
            if (w_push && !w_pop)      r_count <= r_count + PTRW'(1);
            else if (w_pop && !w_push) r_count <= r_count - PTRW'(1);
        end
    end

    // Entry storage is not reset; it is only observed through valid pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_data[w_widx]  <= i_lsu_lden ? i_lsu_lsres : i_lsu_exres;
            r_rdid[w_widx]  <= i_lsu_rdid;
            r_rdwen[w_widx] <= i_lsu_rdwen;
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        o_rs1_hit  = 1'b0;
        o_rs1_data = '0;
        o_rs2_hit  = 1'b0;
        o_rs2_data = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (PTRW'(k) < r_count) begin
                if (r_rdwen[IDXW'(w_ridx + IDXW'(k))] && (i_rs1id != '0)
                    && (r_rdid[IDXW'(w_ridx + IDXW'(k))] == i_rs1id)) begin
                    o_rs1_hit  = 1'b1;
                    o_rs1_data = r_data[IDXW'(w_ridx + IDXW'(k))];
                end
                if (r_rdwen[IDXW'(w_ridx + IDXW'(k))] && (i_rs2id != '0)
                    && (r_rdid[IDXW'(w_ridx + IDXW'(k))] == i_rs2id)) begin
                    o_rs2_hit  = 1'b1;
                    o_rs2_data = r_data[IDXW'(w_ridx + IDXW'(k))];
                end
            end
        end
    end

`ifdef WBU_QUEUE_DIFFTEST_EN
    logic [XLEN-1:0] r_pc  [DEPTH];
    logic [31:0]     r_ins [DEPTH];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc[w_widx]  <= s_lsu_diffpc;
            r_ins[w_widx] <= s_lsu_ins;
        end
    end

    assign s_wbu_diffpc = w_empty ? '0 : r_pc[w_ridx];
    assign s_wbu_ins    = w_empty ? '0 : r_ins[w_ridx];
    assign s_wbu_commit = w_pop;
`endif

endmodule

// File: tb/tb_wbu_queue.sv
// Bench for wbu_queue: directed cases with literal expectations plus random traffic against a queue model.
module tb_wbu_queue;

    localparam int XLEN      = 64;
    localparam int REG_ADDRW = 5;
    localparam int DEPTH     = 2;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 pre_valid;
    logic                 pre_ready;
    logic [XLEN-1:0]      exres;
    logic [XLEN-1:0]      lsres;
    logic [REG_ADDRW-1:0] rdid;
    logic                 rdwen;
    logic                 lden;
    logic                 post_ready;
    logic                 wbu_valid;
    logic                 wbu_rdwen;
    logic [XLEN-1:0]      wbu_rd;
    logic [REG_ADDRW-1:0] wbu_rdid;
    logic [REG_ADDRW-1:0] rs1id;
    logic [REG_ADDRW-1:0] rs2id;
    logic                 rs1_hit;
    logic                 rs2_hit;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [CW-1:0]        wbu_count;

    always #5 clk = ~clk;

    wbu_queue #(
        .XLEN      (XLEN),
        .REG_ADDRW (REG_ADDRW),
        .DEPTH     (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pre_valid  (pre_valid),
        .o_pre_ready  (pre_ready),
        .i_lsu_exres  (exres),
        .i_lsu_lsres  (lsres),
        .i_lsu_rdid   (rdid),
        .i_lsu_rdwen  (rdwen),
        .i_lsu_lden   (lden),
        .i_post_ready (post_ready),
        .o_wbu_valid  (wbu_valid),
        .o_wbu_rdwen  (wbu_rdwen),
        .o_wbu_rd     (wbu_rd),
        .o_wbu_rdid   (wbu_rdid),
        .i_rs1id      (rs1id),
        .i_rs2id      (rs2id),
        .o_rs1_hit    (rs1_hit),
        .o_rs2_hit    (rs2_hit),
        .o_rs1_data   (rs1_data),
        .o_rs2_data   (rs2_data),
        .o_wbu_count  (wbu_count)
    );

    typedef struct packed {
        logic [XLEN-1:0]      data;
        logic [REG_ADDRW-1:0] rdid;
        logic                 rdwen;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest queued producer of rs wins; x0 never forwards.
    function automatic logic [XLEN:0] m_lookup(input logic [REG_ADDRW-1:0] rs);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (rs != 0 && q[i].rdwen && q[i].rdid == rs) return {1'b1, q[i].data};
        end
        return '0;
    endfunction

    function automatic logic m_ready();
        return (q.size() < DEPTH) || post_ready;
    endfunction

    task automatic check_all();
        logic [XLEN:0] l1;
        logic [XLEN:0] l2;
        logic          v;
        l1 = m_lookup(rs1id);
        l2 = m_lookup(rs2id);
        v  = q.size() > 0;
        chk("pre_ready", pre_ready, m_ready());
        chk("valid", wbu_valid, v);
        chk("rdwen", wbu_rdwen, v && post_ready && q[0].rdwen && q[0].rdid != 0);
        chk("rd", wbu_rd, v ? q[0].data : '0);
        chk("rdid", wbu_rdid, v ? q[0].rdid : '0);
        chk("count", wbu_count, q.size());
        chk("rs1_hit", rs1_hit, l1[XLEN]);
        chk("rs1_data", rs1_data, l1[XLEN-1:0]);
        chk("rs2_hit", rs2_hit, l2[XLEN]);
        chk("rs2_data", rs2_data, l2[XLEN-1:0]);
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] ex, input logic [XLEN-1:0] ls,
                         input logic [REG_ADDRW-1:0] id, input logic we, input logic ld,
                         input logic pr, input logic [REG_ADDRW-1:0] r1,
                         input logic [REG_ADDRW-1:0] r2);
        pre_valid  = v;
        exres      = ex;
        lsres      = ls;
        rdid       = id;
        rdwen      = we;
        lden       = ld;
        post_ready = pr;
        rs1id      = r1;
        rs2id      = r2;
        #1;
    endtask

    task automatic step();
        logic m_push;
        logic m_pop;
        ent_t e;
        check_all();
        m_push = pre_valid && m_ready();
        m_pop  = (q.size() > 0) && post_ready;
        e.data  = lden ? lsres : exres;
        e.rdid  = rdid;
        e.rdwen = rdwen;
        @(posedge clk);
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic pr);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, pr, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_valid", wbu_valid, 1'b0);
        chk("reset_count", wbu_count, 0);

        // Single push, drains the next cycle.
        drive(1'b1, 64'h11, 64'h0, 5'd5, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
        chk("t1_no_flowthrough", wbu_valid, 1'b0);
        step();
        idle(1'b1);
        chk("t1_rdwen", wbu_rdwen, 1'b1);
        chk("t1_rd", wbu_rd, 64'h11);
        chk("t1_rdid", wbu_rdid, 5);
        chk("t1_count", wbu_count, 1);
        step();
        idle(1'b1);
        chk("t1_count_after", wbu_count, 0);
        chk("t1_valid_after", wbu_valid, 1'b0);
        step();

        // Fill, then push while popping from full.
        drive(1'b1, 64'hA, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b1, 64'hB, 64'h0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b1, 64'hC, 64'h0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("t2_count_full", wbu_count, 2);
        chk("t2_ready_full", pre_ready, 1'b0);
        drive(1'b1, 64'hC, 64'h0, 5'd6, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
        chk("t2_ready_popping", pre_ready, 1'b1);
        step();
        idle(1'b0);
        chk("t2_count_kept", wbu_count, 2);
        chk("t2_head_b", wbu_rd, 64'hB);
        step();
        idle(1'b1);
        step();
        step();

        // Load result selection.
        drive(1'b1, 64'hBEEF, 64'hDEAD, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        step();
        idle(1'b0);
        chk("t3_lsres", wbu_rd, 64'hDEAD);
        step();
        idle(1'b1);
        step();

        // Bypass: youngest wins, x0 never hits.
        drive(1'b1, 64'h1, 64'h0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b1, 64'h2, 64'h0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0);
        chk("t4_rs1_hit", rs1_hit, 1'b1);
        chk("t4_rs1_data", rs1_data, 64'h2);
        chk("t4_rs2_miss", rs2_hit, 1'b0);
        step();
        idle(1'b1);
        step();
        step();
        drive(1'b1, 64'h5, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
        chk("t4_x0_valid", wbu_valid, 1'b1);
        chk("t4_x0_no_hit", rs2_hit, 1'b0);
        chk("t4_x0_no_rdwen", wbu_rdwen, 1'b0);
        step();

        // rdwen=0 entry drains silently.
        drive(1'b1, 64'h9, 64'h0, 5'd9, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
        step();
        idle(1'b1);
        chk("t5_valid", wbu_valid, 1'b1);
        chk("t5_rdwen", wbu_rdwen, 1'b0);
        step();
        idle(1'b1);
        chk("t5_count", wbu_count, 0);
        step();

        // Asynchronous reset with two entries queued.
        drive(1'b1, 64'h21, 64'h0, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b1, 64'h22, 64'h0, 5'd11, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 5'd10, 5'd11);
        check_all();
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("t6_valid", wbu_valid, 1'b0);
        chk("t6_count", wbu_count, 0);
        chk("t6_rs1_hit", rs1_hit, 1'b0);
        chk("t6_rs2_hit", rs2_hit, 1'b0);
        chk("t6_rdwen", wbu_rdwen, 1'b0);
        chk("t6_rd", wbu_rd, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) < 60),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  REG_ADDRW'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 55),
                  REG_ADDRW'($urandom_range(0, 7)), REG_ADDRW'($urandom_range(0, 7)));
            step();
        end
        idle(1'b1);
        for (int i = 0; i < DEPTH + 1; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
